score_pair_feeder: RTL and testbench

SCORE_PAIR_FEEDER -- requirements
Module: score_pair_feeder

---
 rtl/score_pair_feeder_pkg.sv | 22 ++
 rtl/score_pair_feeder.sv | 132 +++++++++++++
 tb/tb_score_pair_feeder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_pair_feeder_pkg.sv
// Shared definitions for the score pair feeder: state encoding, default
// widths and the pad constants used to complete an odd-length row.
package score_pair_feeder_pkg;

  localparam int CMP_WIDTH_DEF      = 16;
  localparam int LOCATION_WIDTH_DEF = 32;

  // Pad constants are stored wide and sliced by the user to its own width:
  // the top CMP_WIDTH bits of PAD_VALUE_MSB are the most negative signed value,
  // and any slice of PAD_LOC_ONES is the all-ones location.
  localparam logic [63:0] PAD_VALUE_MSB = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PAD_LOC_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  // EVEN: no score held; ODD: one score held waiting for its partner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2,
    ST_DONE = 2'd3
  } feed_state_e;

endpackage

// File: rtl/score_pair_feeder.sv
// Groups a row of streamed signed scores into (slot0, slot1) pairs with their
// locations for the downstream compare stage. Odd rows are completed with a
// minimum-value pad in slot 0 so a real score always wins a tie.
module score_pair_feeder
  import score_pair_feeder_pkg::*;
#(
  parameter int CMP_WIDTH      = CMP_WIDTH_DEF,
  parameter int LOCATION_WIDTH = LOCATION_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CMP_WIDTH-1:0]      s_value,
  input  logic                      s_last,
  input  logic [LOCATION_WIDTH-1:0] base_loc,
  output logic                      m_clear,
  output logic                      m_en,
  output logic [CMP_WIDTH-1:0]      m_value_0,
  output logic [CMP_WIDTH-1:0]      m_value_1,
  output logic [LOCATION_WIDTH-1:0] m_loc_0,
  output logic [LOCATION_WIDTH-1:0] m_loc_1,
  output logic                      row_done,
  output logic [15:0]               pair_count
);

  localparam logic [CMP_WIDTH-1:0]      PAD_VAL = PAD_VALUE_MSB[63 -: CMP_WIDTH];
  localparam logic [LOCATION_WIDTH-1:0] PAD_LOC = PAD_LOC_ONES[LOCATION_WIDTH-1:0];

  feed_state_e               state_q;
  logic [LOCATION_WIDTH-1:0] base_q;
  logic [LOCATION_WIDTH-1:0] idx_q;
  logic [CMP_WIDTH-1:0]      held_val_q;
  logic [LOCATION_WIDTH-1:0] held_loc_q;
  logic [15:0]               cnt_q;
  logic                      m_clear_q, m_en_q, row_done_q;
  logic [CMP_WIDTH-1:0]      val0_q, val1_q;
  logic [LOCATION_WIDTH-1:0] loc0_q, loc1_q;
  logic [15:0]               pair_count_q;

  logic                      accept;
  logic [LOCATION_WIDTH-1:0] cur_loc;

  // Ready is a pure decode of the state register, so it carries no input path.
  assign s_ready = (state_q == ST_EVEN) || (state_q == ST_ODD);
  assign accept  = s_valid && s_ready;
  // Wraps modulo 2^LOCATION_WIDTH by construction.
  assign cur_loc = base_q + idx_q;

  // Row sequencing FSM; all pulses and pair outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      held_val_q   <= '0;
      held_loc_q   <= '0;
      cnt_q        <= '0;
      m_clear_q    <= 1'b0;
      m_en_q       <= 1'b0;
      row_done_q   <= 1'b0;
      val0_q       <= '0;
      val1_q       <= '0;
      loc0_q       <= '0;
      loc1_q       <= '0;
      pair_count_q <= '0;
    end else begin
      m_clear_q  <= 1'b0;
      m_en_q     <= 1'b0;
      row_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // base_loc is only looked at here, so later changes are ignored.
          if (s_valid) begin
            m_clear_q <= 1'b1;
            base_q    <= base_loc;
            idx_q     <= '0;
            cnt_q     <= '0;
            state_q   <= ST_EVEN;
          end
        end
        ST_EVEN: begin
          if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (s_last) begin
              // Odd row: pad goes to slot 0 so ties resolve to the real score.
              val0_q  <= PAD_VAL;
              loc0_q  <= PAD_LOC;
              val1_q  <= s_value;
              loc1_q  <= cur_loc;
              m_en_q  <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              state_q <= ST_DONE;
            end else begin
              held_val_q <= s_value;
              held_loc_q <= cur_loc;
              state_q    <= ST_ODD;
            end
          end
        end
        ST_ODD: begin
          if (accept) begin
            idx_q   <= idx_q + 1'b1;
            val0_q  <= held_val_q;
            loc0_q  <= held_loc_q;
            val1_q  <= s_value;
            loc1_q  <= cur_loc;
            m_en_q  <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= s_last ? ST_DONE : ST_EVEN;
          end
        end
        ST_DONE: begin
          row_done_q   <= 1'b1;
          pair_count_q <= cnt_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_clear    = m_clear_q;
  assign m_en       = m_en_q;
  assign m_value_0  = val0_q;
  assign m_value_1  = val1_q;
  assign m_loc_0    = loc0_q;
  assign m_loc_1    = loc1_q;
  assign row_done   = row_done_q;
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_score_pair_feeder.sv
// Bench for score_pair_feeder: directed rows plus random rows with random
// s_valid gaps, checked against a row-level pairing model.
module tb_score_pair_feeder;

  localparam int CW = 16;
  localparam int LW = 32;
  localparam logic [CW-1:0] MINV = 16'h8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_value = '0;
  logic          s_last = 1'b0;
  logic [LW-1:0] base_loc = '0;
  logic          m_clear, m_en, row_done;
  logic [CW-1:0] m_value_0, m_value_1;
  logic [LW-1:0] m_loc_0, m_loc_1;
  logic [15:0]   pair_count;

  score_pair_feeder #(.CMP_WIDTH(CW), .LOCATION_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_value(s_value), .s_last(s_last),
    .base_loc(base_loc),
    .m_clear(m_clear), .m_en(m_en),
    .m_value_0(m_value_0), .m_value_1(m_value_1),
    .m_loc_0(m_loc_0), .m_loc_1(m_loc_1),
    .row_done(row_done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] v0;
    logic [CW-1:0] v1;
    logic [LW-1:0] l0;
    logic [LW-1:0] l1;
    int            c;
  } pair_t;

  int            hs_q[$];
  int            clr_q[$];
  pair_t         pr_q[$];
  int            rd_cyc[$];
  logic [15:0]   rd_cnt[$];
  logic [CW-1:0] rv[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe handshakes and output pulses mid-cycle, tagged with cycle number.
  always @(negedge clk) begin
    if (s_valid && s_ready) hs_q.push_back(cyc);
    if (m_clear) clr_q.push_back(cyc);
    if (m_en) pr_q.push_back('{m_value_0, m_value_1, m_loc_0, m_loc_1, cyc});
    if (row_done) begin
      rd_cyc.push_back(cyc);
      rd_cnt.push_back(pair_count);
    end
  end

  task automatic clear_logs();
    hs_q.delete(); clr_q.delete(); pr_q.delete(); rd_cyc.delete(); rd_cnt.delete();
  endtask

  // Hold the current beat until it is accepted; returns 0 on timeout.
  task automatic wait_hs(output bit got);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = s_valid && s_ready;
      @(posedge clk); #1;
    end
  endtask

  // Drive row rv[] and check the emitted pairs against the pairing rule.
  task automatic send_row(input string nm, input logic [LW-1:0] base, input int gap_pct);
    int            n, np, sec;
    bit            got;
    logic [CW-1:0] ev0, ev1;
    logic [LW-1:0] el0, el1;
    n = rv.size();
    clear_logs();
    base_loc = base;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0; s_value = CW'($urandom); s_last = 1'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1; s_value = rv[i]; s_last = (i == n - 1);
      if (i > 0) base_loc = $urandom;
      wait_hs(got);
      if (!got) begin
        chk({nm, "_timeout"}, 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    np = (n + 1) / 2;
    chk({nm, "_hs"}, hs_q.size(), n);
    chk({nm, "_clr"}, clr_q.size(), 1);
    chk({nm, "_npair"}, pr_q.size(), np);
    if (clr_q.size() > 0 && pr_q.size() > 0)
      chk({nm, "_clr_first"}, clr_q[0] < pr_q[0].c, 1);
    for (int k = 0; k < np && k < pr_q.size(); k++) begin
      if (2 * k + 1 < n) begin
        ev0 = rv[2*k];  el0 = base + LW'(2 * k);
        ev1 = rv[2*k+1]; el1 = base + LW'(2 * k + 1);
        sec = 2 * k + 1;
      end else begin
        ev0 = MINV;      el0 = '1;
        ev1 = rv[n-1];   el1 = base + LW'(n - 1);
        sec = n - 1;
      end
      chk($sformatf("%s_v0[%0d]", nm, k), pr_q[k].v0, ev0);
      chk($sformatf("%s_v1[%0d]", nm, k), pr_q[k].v1, ev1);
      chk($sformatf("%s_l0[%0d]", nm, k), pr_q[k].l0, el0);
      chk($sformatf("%s_l1[%0d]", nm, k), pr_q[k].l1, el1);
      if (sec < hs_q.size())
        chk($sformatf("%s_lat[%0d]", nm, k), pr_q[k].c, hs_q[sec] + 1);
      if (k == np - 1) begin
        chk({nm, "_hold_v1"}, m_value_1, ev1);
        chk({nm, "_hold_l0"}, m_loc_0, el0);
      end
    end
    chk({nm, "_rowdone"}, rd_cyc.size(), 1);
    if (rd_cyc.size() > 0) begin
      chk({nm, "_pcount"}, rd_cnt[0], np);
      if (pr_q.size() > 0)
        chk({nm, "_rd_after"}, rd_cyc[0] > pr_q[pr_q.size()-1].c, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [LW-1:0] b;
    int n;
    // Reset state
    #12;
    chk("rst_ready", s_ready, 0);
    chk("rst_men", m_en, 0);
    chk("rst_clr", m_clear, 0);
    chk("rst_rd", row_done, 0);
    chk("rst_vals", {m_value_0, m_value_1}, 0);
    chk("rst_locs", {m_loc_0, m_loc_1}, 0);
    chk("rst_pcnt", pair_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rv = '{16'd5, 16'hFFFD, 16'd7, 16'd7};
    send_row("row4", 32'd100, 0);
    rv = '{16'd1, 16'd2, 16'd9};
    send_row("row3", 32'd0, 0);
    rv = '{MINV};
    send_row("single_min", 32'd4321, 0);
    rv = '{16'd10, 16'd20, 16'd30, 16'd40};
    send_row("wrap", 32'hFFFF_FFFE, 0);
    rv = '{16'd3, 16'h8001, 16'd77, 16'hFFFF, 16'd0};
    send_row("gap_free", 32'h55, 0);
    send_row("gappy", 32'h55, 70);

    // Reset while one score is held: nothing may be emitted.
    clear_logs();
    base_loc = 32'd500; s_value = 16'd11; s_last = 1'b0; s_valid = 1'b1;
    wait_hs(got);
    chk("mid_hs", got, 1);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_pulses", {m_en, m_clear, row_done}, 0);
    chk("mid_rst_vals", {m_value_0, m_value_1}, 0);
    chk("mid_rst_locs", {m_loc_0, m_loc_1}, 0);
    chk("mid_rst_pcnt", pair_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_men", pr_q.size(), 0);
    chk("mid_no_rd", rd_cyc.size(), 0);
    rv = '{16'd8, 16'd9};
    send_row("after_rst", 32'd700, 0);

    // Random rows, alternating gap-free and gappy valid.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 12);
      rv.delete();
      for (int i = 0; i < n; i++)
        rv.push_back(($urandom_range(4) == 0) ? MINV : CW'($urandom));
      b = (r % 3 == 0) ? (32'hFFFF_FFFF - LW'($urandom_range(8))) : LW'($urandom);
      send_row($sformatf("rnd%0d", r), b, (r % 2) ? 50 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
